mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

- Shares one single-ported memory between the instruction fetch requester and the load/store (data) requester of the cpu core.
- Accepts requests over valid/ready handshakes and serialises them onto the memory with at most one transaction outstanding.
- Returns each response to the requester that owns the transaction.
- Sits between `fetch`/`execute` and the memory; the core stalls on `*_req_ready`/`*_resp_valid`.

## Interface
Parameters:
- ADDR_WIDTH, default REGISTER_WIDTH (32): byte address width.
- DATA_WIDTH, default REGISTER_WIDTH (32): data width.
- MAX_DATA_STREAK, default 4: consecutive data grants allowed while a fetch is pending (≥1).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- fetch_req_valid  in  1  fetch request pending.
- fetch_req_ready  out  1  fetch request accepted this cycle.
- fetch_addr  in  ADDR_WIDTH  fetch address; stable while valid && !ready.
- fetch_flush  in  1  cancel the in-flight fetch (branch taken).
- fetch_resp_valid  out  1  one-cycle pulse; fetch_rdata valid.
- fetch_rdata  out  DATA_WIDTH  instruction word.
- data_req_valid  in  1  load/store request pending.
- data_req_ready  out  1  data request accepted this cycle.
- data_addr  in  ADDR_WIDTH  load/store address.
- data_we  in  1  1 = store, 0 = load.
- data_wdata  in  DATA_WIDTH  store data.
- data_resp_valid  out  1  one-cycle pulse; load data or store ack.
- data_rdata  out  DATA_WIDTH  load data; 0 for stores.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts.
- mem_addr  out  ADDR_WIDTH  registered address.
- mem_we  out  1  registered write enable.
- mem_wdata  out  DATA_WIDTH  registered write data.
- mem_rvalid  in  1  memory response. The memory asserts it exactly once per accepted request (stores included), no earlier than the cycle after acceptance.
- mem_rdata  in  DATA_WIDTH  memory read data.

## Operation
- FSM states IDLE, ISSUE, WAIT.
- **IDLE**
  - If either request valid, grant exactly one: assert its `*_req_ready` combinationally from valid and state only.
  - Latch addr, we, wdata and owner (FETCH/DATA); go to ISSUE.
- **Arbitration**
  - Data wins by default.
  - Fetch wins if `streak == MAX_DATA_STREAK` and fetch is valid.
  - `streak` increments on each data grant made while fetch_req_valid=1, saturating at MAX_DATA_STREAK.
  - `streak` clears on any fetch grant and on any data grant made with fetch_req_valid=0.
- **ISSUE**
  - mem_req_valid=1 with latched fields.
  - On mem_req_ready, go to WAIT. Fields are held unchanged until then.
- **WAIT**
  - On mem_rvalid, register mem_rdata into the owner's rdata (data_rdata=0 if store).
  - Pulse the owner's resp_valid next cycle; go to IDLE.
- **Flush**
  - fetch_flush while the owner is FETCH (accept cycle, ISSUE or WAIT) sets `cancel`.
  - The memory transaction still completes, but fetch_resp_valid is suppressed and fetch_rdata is unchanged.
  - Flush in the cycle fetch_resp_valid=1 has no effect; that response is delivered.
  - Flush with no fetch in flight is ignored. `cancel` clears on return to IDLE.
- mem_rvalid outside WAIT is ignored.
- Stores never update fetch_rdata; loads never update it either.
- Reset (any cycle, mid-transaction included):
  - All outputs 0, state IDLE, streak 0, cancel 0, registers 0.
  - Any in-flight transaction is dropped and no response is produced.

## Timing
- Min latency with mem_req_ready=1 and a 1-cycle memory:
  - accept at N, mem_req_valid at N+1, mem_rvalid at N+2, resp_valid at N+3.
  - New accept possible at N+3 (IDLE), giving a 3-cycle request-to-request throughput.
- `*_req_ready` is asserted only in IDLE; never both in one cycle.
- resp_valid is exactly 1 cycle; rdata holds its value until the next response to the same owner.
- Memory backpressure extends ISSUE indefinitely without loss.
- Reset deassertion: first accept is possible in the first clk edge after rst=1.

## Structure
- Shared package `common`: `arb_state_t` enum (IDLE, ISSUE, WAIT) and `arb_owner_t` enum (FETCH, DATA).
- `MAX_DATA_STREAK` default also as a package constant.
- One sub-module is natural: `arb_pick`. It is combinational and holds the priority plus streak compare, giving grant_fetch and grant_data.
- FSM, streak counter, latches and response registers stay in `mem_port_arbiter`.

## Test plan
- **Single load:** data_req addr=0x10, mem returns 0xDEADBEEF 1 cycle after accept → data_resp_valid at N+3 with data_rdata=0xDEADBEEF, fetch_resp_valid stays 0.
- **Contention:** both valid continuously, MAX_DATA_STREAK=4 → grant order D,D,D,D,F,D,D,D,D,F; no fetch starvation.
- **Backpressure:** store addr=0x20 wdata=0x55, mem_req_ready low 5 cycles → mem_addr/mem_wdata/mem_we stable 5 cycles, one data_resp_valid after ack, data_rdata=0.
- **Flush:** fetch addr=0x100 accepted, fetch_flush in WAIT → no fetch_resp_valid, fetch_rdata unchanged. The next fetch at 0x200 returns normally.
- **Reset mid-operation:** rst=0 during WAIT → all outputs 0 immediately. mem_rvalid after release is ignored, and the next request completes normally.
- **Stray response:** mem_rvalid pulsed in IDLE → no resp_valid on either port.

Source files
------------

// File: rtl/common.sv
// Shared types and constants for the memory port arbiter.
package common;
  localparam int REGISTER_WIDTH = 32;
  localparam int DEF_MAX_DATA_STREAK = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } arb_owner_t;
endpackage

// File: rtl/arb_pick.sv
// Combinational grant selection: data first, fetch once the data streak is exhausted.
module arb_pick #(
  parameter int SW  = 3,
  parameter int MAX = 4
) (
  input  logic          fetch_valid,
  input  logic          data_valid,
  input  logic [SW-1:0] streak,
  output logic          grant_fetch,
  output logic          grant_data
);
  logic fetch_due;

  assign fetch_due   = fetch_valid && (streak == SW'(MAX));
  assign grant_data  = data_valid && !fetch_due;
  assign grant_fetch = fetch_valid && !grant_data;
endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and load/store requests onto one memory port, one transaction at a time.
// Handshake: a request transfers on a rising edge where *_req_valid && *_req_ready (or mem_req_valid && mem_req_ready) are both 1.
module mem_port_arbiter
  import common::*;
#(
  parameter int ADDR_WIDTH      = REGISTER_WIDTH,
  parameter int DATA_WIDTH      = REGISTER_WIDTH,
  parameter int MAX_DATA_STREAK = DEF_MAX_DATA_STREAK
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req_valid,
  output logic                  fetch_req_ready,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic                  fetch_flush,
  output logic                  fetch_resp_valid,
  output logic [DATA_WIDTH-1:0] fetch_rdata,
  input  logic                  data_req_valid,
  output logic                  data_req_ready,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic                  data_we,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  data_resp_valid,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]            dbg_state
);
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);

  arb_state_t    state;
  arb_owner_t    owner;
  logic          cancel;
  logic [SW-1:0] streak;
  logic          grant_fetch;
  logic          grant_data;
  logic          fetch_owned;

  arb_pick #(.SW(SW), .MAX(MAX_DATA_STREAK)) u_pick (
    .fetch_valid (fetch_req_valid),
    .data_valid  (data_req_valid),
    .streak      (streak),
    .grant_fetch (grant_fetch),
    .grant_data  (grant_data)
  );

  assign fetch_req_ready = (state == IDLE) && grant_fetch;
  assign data_req_ready  = (state == IDLE) && grant_data;
  assign mem_req_valid   = (state == ISSUE);
  assign dbg_state       = state;
  assign fetch_owned     = (state != IDLE) && (owner == FETCH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      owner            <= FETCH;
      cancel           <= 1'b0;
      streak           <= '0;
      mem_addr         <= '0;
      mem_we           <= 1'b0;
      mem_wdata        <= '0;
      fetch_resp_valid <= 1'b0;
      fetch_rdata      <= '0;
      data_resp_valid  <= 1'b0;
      data_rdata       <= '0;
    end else begin
      fetch_resp_valid <= 1'b0;
      data_resp_valid  <= 1'b0;
      if (fetch_owned && fetch_flush) cancel <= 1'b1;
      case (state)
        IDLE: begin
          if (data_req_ready) begin
            state     <= ISSUE;
            owner     <= DATA;
            mem_addr  <= data_addr;
            mem_we    <= data_we;
            mem_wdata <= data_wdata;
            // Streak only counts data grants that actually held off a waiting fetch.
            if (!fetch_req_valid) streak <= '0;
            else if (streak != SW'(MAX_DATA_STREAK)) streak <= streak + SW'(1);
          end else if (fetch_req_ready) begin
            state     <= ISSUE;
            owner     <= FETCH;
            mem_addr  <= fetch_addr;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            streak    <= '0;
            cancel    <= fetch_flush;
          end
        end
        ISSUE: begin
          if (mem_req_ready) state <= WAIT;
        end
        WAIT: begin
          if (mem_rvalid) begin
            state  <= IDLE;
            cancel <= 1'b0;
            if (owner == DATA) begin
              data_resp_valid <= 1'b1;
              data_rdata      <= mem_we ? '0 : mem_rdata;
            end else if (!cancel && !fetch_flush) begin
              fetch_resp_valid <= 1'b1;
              fetch_rdata      <= mem_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a small memory model answers requests, expected responses are queued at accept time.
module tb_mem_port_arbiter;
  import common::*;

  logic        clk;
  logic        rst;
  logic        fetch_req_valid, fetch_req_ready, fetch_flush, fetch_resp_valid;
  logic [31:0] fetch_addr, fetch_rdata;
  logic        data_req_valid, data_req_ready, data_we, data_resp_valid;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;

  logic [31:0] fetch_exp_q[$];
  logic [31:0] data_exp_q[$];
  logic        grant_q[$];
  logic [31:0] last_fetch;
  int          n_cmp = 0;
  int          n_err = 0;

  int          mem_lat;
  logic        stray_req;
  logic        acc_pend;
  logic [31:0] acc_addr;
  int          rsp_cnt;
  logic [31:0] rsp_data;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
    .fetch_addr(fetch_addr), .fetch_flush(fetch_flush),
    .fetch_resp_valid(fetch_resp_valid), .fetch_rdata(fetch_rdata),
    .data_req_valid(data_req_valid), .data_req_ready(data_req_ready),
    .data_addr(data_addr), .data_we(data_we), .data_wdata(data_wdata),
    .data_resp_valid(data_resp_valid), .data_rdata(data_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  // Memory model: answers mem_lat cycles after each accepted request
  always @(negedge clk) begin
    acc_pend = mem_req_valid && mem_req_ready && rst;
    acc_addr = mem_addr;
  end

  always @(posedge clk) begin
    #1;
    mem_rvalid = 1'b0;
    if (stray_req) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hBADBAD00;
      stray_req  = 1'b0;
    end
    if (acc_pend) begin
      rsp_cnt  = mem_lat;
      rsp_data = mem_data(acc_addr);
    end
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rsp_data;
      end
    end
  end

  // Scoreboard: push on accept, pop and compare on response
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst) begin
      if (fetch_req_valid && fetch_req_ready) begin
        grant_q.push_back(1'b0);
        fetch_exp_q.push_back(mem_data(fetch_addr));
      end
      if (data_req_valid && data_req_ready) begin
        grant_q.push_back(1'b1);
        data_exp_q.push_back(data_we ? 32'h0 : mem_data(data_addr));
      end
      if (fetch_resp_valid) begin
        if (fetch_exp_q.size() == 0) check("fetch_unexpected_resp", 1, 0);
        else begin
          e = fetch_exp_q.pop_front();
          last_fetch = e;
          check("fetch_rdata", fetch_rdata, e);
        end
      end
      if (data_resp_valid) begin
        if (data_exp_q.size() == 0) check("data_unexpected_resp", 1, 0);
        else begin
          e = data_exp_q.pop_front();
          check("data_rdata", data_rdata, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input bit is_data, input logic [31:0] addr, input bit we, input logic [31:0] wdata);
    bit done = 1'b0;
    if (is_data) begin
      data_req_valid = 1'b1; data_addr = addr; data_we = we; data_wdata = wdata;
    end else begin
      fetch_req_valid = 1'b1; fetch_addr = addr;
    end
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (is_data ? data_req_ready : fetch_req_ready) done = 1'b1;
    end
    if (!done) check("req_accept_timeout", 0, 1);
    tick();
    if (is_data) data_req_valid = 1'b0;
    else fetch_req_valid = 1'b0;
  endtask

  task automatic wait_resp(input bit is_data);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (is_data ? data_resp_valid : fetch_resp_valid) seen = 1'b1;
    end
    if (!seen) check(is_data ? "data_resp_timeout" : "fetch_resp_timeout", 0, 1);
    tick();
  endtask

  task automatic drain();
    bit empty = 1'b0;
    for (int i = 0; i < 200 && !empty; i++) begin
      tick();
      empty = (fetch_exp_q.size() == 0) && (data_exp_q.size() == 0);
    end
    if (!empty) check("drain_timeout", 0, 1);
  endtask

  task automatic check_quiet(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("no_fetch_resp", fetch_resp_valid, 0);
      check("no_data_resp", data_resp_valid, 0);
    end
    tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_fetch_ready"}, fetch_req_ready, 0);
    check({tag, "_data_ready"}, data_req_ready, 0);
    check({tag, "_fetch_resp_valid"}, fetch_resp_valid, 0);
    check({tag, "_data_resp_valid"}, data_resp_valid, 0);
    check({tag, "_fetch_rdata"}, fetch_rdata, 0);
    check({tag, "_data_rdata"}, data_rdata, 0);
    check({tag, "_mem_req_valid"}, mem_req_valid, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    rst = 1'b0;
    fetch_req_valid = 0; fetch_addr = 0; fetch_flush = 0;
    data_req_valid = 0; data_addr = 0; data_we = 0; data_wdata = 0;
    mem_req_ready = 1; mem_rvalid = 0; mem_rdata = 0;
    mem_lat = 1; stray_req = 0; acc_pend = 0; acc_addr = 0; rsp_cnt = 0; rsp_data = 0;
    last_fetch = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    tick();
    rst = 1'b1;

    // Single load with exact latency
    do_req(1'b1, 32'h10, 1'b0, 32'h0);
    @(negedge clk);
    check("load_mem_req_valid", mem_req_valid, 1);
    check("load_mem_addr", mem_addr, 32'h10);
    check("load_mem_we", mem_we, 0);
    @(negedge clk);
    check("load_resp_early", data_resp_valid, 0);
    @(negedge clk);
    check("load_resp_n3", data_resp_valid, 1);
    check("load_rdata", data_rdata, 32'hDEADBEEF);
    check("load_no_fetch_resp", fetch_resp_valid, 0);
    tick();

    // Contention: both requesters valid continuously
    grant_q.delete();
    fetch_req_valid = 1; fetch_addr = 32'h300;
    data_req_valid = 1; data_addr = 32'h400; data_we = 0;
    for (int i = 0; i < 100 && grant_q.size() < 10; i++) tick();
    fetch_req_valid = 0; data_req_valid = 0;
    check("grant_count", grant_q.size(), 10);
    for (int i = 0; i < 10 && i < grant_q.size(); i++)
      check($sformatf("grant_%0d", i), grant_q[i], (i % 5 == 4) ? 0 : 1);
    drain();

    // Backpressure on a store
    mem_req_ready = 0;
    do_req(1'b1, 32'h20, 1'b1, 32'h55);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_mem_req_valid", mem_req_valid, 1);
      check("bp_mem_addr", mem_addr, 32'h20);
      check("bp_mem_wdata", mem_wdata, 32'h55);
      check("bp_mem_we", mem_we, 1);
    end
    tick();
    mem_req_ready = 1;
    wait_resp(1'b1);
    @(negedge clk);
    check("bp_single_resp", data_resp_valid, 0);
    tick();

    // Flush of an in-flight fetch
    mem_lat = 3;
    do_req(1'b0, 32'h100, 1'b0, 32'h0);
    tick();
    check("flush_in_wait", dbg_state, 2);
    fetch_flush = 1;
    void'(fetch_exp_q.pop_back());
    tick();
    fetch_flush = 0;
    check_quiet(6);
    check("flush_rdata_kept", fetch_rdata, last_fetch);
    mem_lat = 1;
    do_req(1'b0, 32'h200, 1'b0, 32'h0);
    wait_resp(1'b0);
    check("fetch_after_flush", fetch_rdata, mem_data(32'h200));

    // Randomised mix with variable memory latency
    for (int n = 0; n < 12; n++) begin
      bit d;
      d = 1'($urandom_range(0, 1));
      mem_lat = $urandom_range(1, 4);
      do_req(d, 32'($urandom_range(0, 255)) << 2, d ? 1'($urandom_range(0, 1)) : 1'b0, $urandom);
      wait_resp(d);
    end
    drain();

    // Reset during WAIT, late memory response must be ignored
    mem_lat = 3;
    do_req(1'b1, 32'h44, 1'b0, 32'h0);
    tick();
    check("rst_in_wait", dbg_state, 2);
    rst = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    fetch_exp_q.delete();
    data_exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    check_quiet(4);
    mem_lat = 1;
    do_req(1'b1, 32'h48, 1'b0, 32'h0);
    wait_resp(1'b1);
    check("after_reset_rdata", data_rdata, mem_data(32'h48));

    // Stray memory response while idle
    stray_req = 1;
    check_quiet(3);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
